// File: rtl/data_serializer.sv
// data_serializer: snapshots a STAGE-word frame on load and streams it one word per clock with start/done framing.
module data_serializer #(
    parameter int STAGE  = 8,
    parameter int DWIDTH = 8,
    parameter int GAP    = 1,
    parameter int IW     = $clog2(STAGE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              abort,
    input  logic [DWIDTH-1:0] data_d [0:STAGE-1],
    output logic              ready,
    output logic              start,
    output logic [DWIDTH-1:0] data,
    output logic              dvalid,
    output logic [IW-1:0]     idx,
    output logic              last,
    output logic              done
);
    localparam int GN = (GAP < 1) ? 1 : GAP;
    localparam int GW = $clog2(GN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_SHIFT, S_GAP} state_t;

    state_t            state, state_n;
    logic [IW-1:0]     cnt, cnt_n;
    logic [GW-1:0]     gcnt, gcnt_n;
    logic              take;
    logic [DWIDTH-1:0] snap [0:STAGE-1];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gcnt_n  = gcnt;
        take    = 1'b0;
        case (state)
            S_IDLE: begin
                take    = load;
                state_n = load ? S_START : S_IDLE;
            end
            S_START: begin
                state_n = S_SHIFT;
                cnt_n   = '0;
            end
            S_SHIFT: begin
                state_n = (cnt == IW'(STAGE - 1)) ? S_GAP : S_SHIFT;
                cnt_n   = (cnt == IW'(STAGE - 1)) ? '0 : cnt + 1'b1;
                gcnt_n  = '0;
            end
            S_GAP: begin
                state_n = (gcnt == GW'(GN - 1)) ? S_IDLE : S_GAP;
                gcnt_n  = gcnt + 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        // abort only matters while busy; in IDLE load keeps priority
        if (abort && state != S_IDLE) state_n = S_IDLE;
    end

    // outputs are registered decodes of the next state so they line up with it
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            gcnt   <= '0;
            snap   <= '{default: '0};
            ready  <= 1'b1;
            start  <= 1'b0;
            dvalid <= 1'b0;
            data   <= '0;
            idx    <= '0;
            last   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            gcnt   <= gcnt_n;
            if (take) snap <= data_d;
            ready  <= state_n == S_IDLE;
            start  <= state_n == S_START;
            dvalid <= state_n == S_SHIFT;
            data   <= (state_n == S_SHIFT) ? snap[cnt_n] : '0;
            idx    <= (state_n == S_SHIFT) ? cnt_n : '0;
            last   <= state_n == S_SHIFT && cnt_n == IW'(STAGE - 1);
            done   <= state == S_SHIFT && state_n == S_GAP;
        end
    end
endmodule

// File: tb/tb_data_serializer.sv
// tb_data_serializer: three serializer configurations driven one at a time, checked by a timeline model and event scoreboard.
module tb_data_serializer;
    typedef struct {
        int k;
        int c;
        int kind;
        int d;
        int i;
        bit l;
    } ev_t;

    function automatic int st_of(input int k); return k == 0 ? 8 : (k == 1 ? 2 : 16); endfunction
    function automatic int dw_of(input int k); return k == 2 ? 12 : 8; endfunction
    function automatic int gn_of(input int k); return k == 0 ? 1 : (k == 1 ? 1 : 4); endfunction

    ev_t  q[$];
    int   cyc = 0, n_cmp = 0, n_bad = 0;
    int   acc [3];
    int   idle_from [3];
    bit   chk_en = 0;

    logic        clk = 0, rst = 0;
    logic [2:0]  ld = '0, ab = '0, rdy, st, dv, ls, dn;
    logic [11:0] din [3][16];
    logic [11:0] nxt [3][16];
    logic [11:0] dat [3];
    logic [3:0]  ix [3];

    logic [7:0]  dd0 [0:7];
    logic [7:0]  dd1 [0:1];
    logic [11:0] dd2 [0:15];
    logic [7:0]  q0, q1;
    logic [11:0] q2;
    logic [2:0]  i0;
    logic        i1;
    logic [3:0]  i2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int j = 0; j < 8; j++) dd0[j] = din[0][j][7:0];
        for (int j = 0; j < 2; j++) dd1[j] = din[1][j][7:0];
        for (int j = 0; j < 16; j++) dd2[j] = din[2][j];
    end

    assign dat[0] = {4'b0, q0};
    assign dat[1] = {4'b0, q1};
    assign dat[2] = q2;
    assign ix[0]  = {1'b0, i0};
    assign ix[1]  = {3'b0, i1};
    assign ix[2]  = i2;

    data_serializer u0 (
        .clk(clk), .rst(rst), .load(ld[0]), .abort(ab[0]), .data_d(dd0),
        .ready(rdy[0]), .start(st[0]), .data(q0), .dvalid(dv[0]), .idx(i0), .last(ls[0]), .done(dn[0])
    );
    data_serializer #(.STAGE(2), .GAP(0)) u1 (
        .clk(clk), .rst(rst), .load(ld[1]), .abort(ab[1]), .data_d(dd1),
        .ready(rdy[1]), .start(st[1]), .data(q1), .dvalid(dv[1]), .idx(i1), .last(ls[1]), .done(dn[1])
    );
    data_serializer #(.STAGE(16), .DWIDTH(12), .GAP(4)) u2 (
        .clk(clk), .rst(rst), .load(ld[2]), .abort(ab[2]), .data_d(dd2),
        .ready(rdy[2]), .start(st[2]), .data(q2), .dvalid(dv[2]), .idx(i2), .last(ls[2]), .done(dn[2])
    );

    task automatic purge(input int c);
        ev_t keep[$];
        foreach (q[j]) if (q[j].c <= c) keep.push_back(q[j]);
        q = keep;
    endtask

    // Timeline model: inputs driven in cycle c take effect in cycle c+1.
    task automatic model(input int k, input bit l, input bit a, input bit r);
        ev_t e;
        int  s;
        s = st_of(k);
        if (!r) begin
            purge(cyc);
            for (int j = 0; j < 3; j++) if (idle_from[j] > cyc + 1) idle_from[j] = cyc + 1;
        end else if (l && cyc >= idle_from[k]) begin
            acc[k] = cyc;
            e = '{k: k, c: cyc + 1, kind: 0, d: 0, i: 0, l: 0};
            q.push_back(e);
            for (int i = 0; i < s; i++) begin
                e = '{k: k, c: cyc + 2 + i, kind: 1, d: int'(din[k][i]) & ((1 << dw_of(k)) - 1), i: i, l: (i == s - 1)};
                q.push_back(e);
            end
            e = '{k: k, c: cyc + s + 2, kind: 2, d: 0, i: 0, l: 0};
            q.push_back(e);
            idle_from[k] = cyc + s + 2 + gn_of(k);
        end else if (a && cyc > acc[k] && cyc < idle_from[k]) begin
            purge(cyc);
            idle_from[k] = cyc + 1;
        end
    endtask

    task automatic tick(input int k, input bit l, input bit a, input bit r);
        @(posedge clk);
        #1;
        chk_en = 1;
        for (int m = 0; m < 3; m++) for (int j = 0; j < 16; j++) din[m][j] = nxt[m][j];
        rst = r;
        for (int j = 0; j < 3; j++) begin
            ld[j] = (j == k) && l;
            ab[j] = (j == k) && a;
        end
        model(k, l, a, r);
    endtask

    task automatic idle(input int k, input int n);
        for (int t = 0; t < n; t++) tick(k, 0, 0, 1);
    endtask

    task automatic set_ramp(input int k);
        for (int j = 0; j < 16; j++) nxt[k][j] = 12'(16 + 17 * j);
    endtask

    task automatic set_rand(input int k);
        for (int j = 0; j < 16; j++) nxt[k][j] = 12'($urandom);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            while (q.size() > 0 && q[0].c < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_event inst=%0d kind=%0d: got nothing, required at cycle %0d (now %0d)", q[0].k, q[0].kind, q[0].c, cyc);
                void'(q.pop_front());
            end
            for (int k = 0; k < 3; k++) begin
                bit   exp_r;
                int   kind;
                ev_t  e;
                exp_r = !(cyc > acc[k] && cyc < idle_from[k]);
                n_cmp++;
                if (rdy[k] !== exp_r) begin
                    n_bad++;
                    $display("FAIL ready inst=%0d cyc=%0d got=%b required=%b", k, cyc, rdy[k], exp_r);
                end
                n_cmp++;
                if ((int'(st[k]) + int'(dv[k]) + int'(dn[k])) > 1 || $isunknown({st[k], dv[k], dn[k]}) ||
                    (!dv[k] && (dat[k] !== 12'd0 || ix[k] !== 4'd0 || ls[k] !== 1'b0))) begin
                    n_bad++;
                    $display("FAIL strobes inst=%0d cyc=%0d got start=%b dvalid=%b done=%b data=%h idx=%0d last=%b required exclusive strobes and zero idle data",
                             k, cyc, st[k], dv[k], dn[k], dat[k], ix[k], ls[k]);
                end
                if (st[k] === 1'b1 || dv[k] === 1'b1 || dn[k] === 1'b1) begin
                    kind = st[k] ? 0 : (dv[k] ? 1 : 2);
                    n_cmp++;
                    if (q.size() == 0 || q[0].c != cyc) begin
                        n_bad++;
                        $display("FAIL unexpected_event inst=%0d cyc=%0d got kind=%0d data=%h idx=%0d, required no event", k, cyc, kind, dat[k], ix[k]);
                    end else begin
                        e = q.pop_front();
                        if (e.k != k || e.kind != kind || dat[k] !== 12'(e.d) || ix[k] !== 4'(e.i) || ls[k] !== e.l) begin
                            n_bad++;
                            $display("FAIL event inst=%0d cyc=%0d got kind=%0d data=%h idx=%0d last=%b required inst=%0d kind=%0d data=%h idx=%0d last=%b",
                                     k, cyc, kind, dat[k], ix[k], ls[k], e.k, e.kind, e.d, e.i, e.l);
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            acc[k] = -10;
            idle_from[k] = 0;
            for (int j = 0; j < 16; j++) begin
                nxt[k][j] = 12'($urandom);
                din[k][j] = nxt[k][j];
            end
        end
        // reset held with load high, released with load still high
        for (int t = 0; t < 3; t++) tick(0, 1, 0, 0);
        tick(0, 1, 0, 1);
        idle(0, 14);
        // basic ramp frame
        set_ramp(0);
        tick(0, 1, 0, 1);
        idle(0, 12);
        // load held high, source words changed mid-frame
        for (int t = 0; t < 25; t++) begin
            if (t == 3) for (int j = 0; j < 16; j++) nxt[0][j] = 12'hFF;
            tick(0, 1, 0, 1);
        end
        idle(0, 12);
        // abort while word 3 is on the bus, then reload immediately
        set_ramp(0);
        tick(0, 1, 0, 1);
        idle(0, 4);
        tick(0, 0, 1, 1);
        tick(0, 1, 0, 1);
        idle(0, 12);
        // abort+load in IDLE accepts; abort+load in SHIFT cancels
        set_rand(0);
        tick(0, 1, 1, 1);
        idle(0, 3);
        tick(0, 1, 1, 1);
        idle(0, 12);
        // reset mid-frame
        tick(0, 1, 0, 1);
        idle(0, 4);
        tick(0, 0, 0, 0);
        idle(0, 12);
        // other configurations: single frame then back-to-back frames
        for (int k = 1; k < 3; k++) begin
            set_ramp(k);
            tick(k, 1, 0, 1);
            idle(k, 30);
            for (int t = 0; t < 3 * (st_of(k) + 2 + gn_of(k)); t++) begin
                set_rand(k);
                tick(k, 1, 0, 1);
            end
            idle(k, 30);
        end
        // random traffic on each configuration
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 300; t++) begin
                set_rand(k);
                tick(k, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) != 0);
            end
            idle(k, 30);
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_events got=%0d pending required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_serializer.md
# data_serializer

Parallel-to-serial frame transmitter that produces the stream consumed by the block-capture latch. On a load request it snapshots STAGE words of DWIDTH bits and emits a one-cycle `start` marker, then one word per clock in index order, then a `done` pulse and a programmable idle gap. It sits on the producer side of the frame interface, between the parallel word source and the downstream latch.

## Interface
- `STAGE`, 8: words per frame; at least 2.
- `DWIDTH`, 8: bits per word.
- `GAP`, 1: idle cycles enforced after `done` before `ready` reasserts; at least 0.
- `IW`, `$clog2(STAGE)`: index width (derived; do not override).

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `load`  in  1  frame request; accepted only in a cycle where `ready`=1.
- `abort`  in  1  synchronous frame cancel.
- `data_d[0:STAGE-1]`  in  DWIDTH each  parallel frame words; sampled only on an accepted `load`.
- `ready`  out  1  block idle and able to accept `load`.
- `start`  out  1  one-cycle frame marker.
- `data`  out  DWIDTH  current serial word.
- `dvalid`  out  1  `data` carries a frame word.
- `idx`  out  IW  index of the word on `data`.
- `last`  out  1  marks word STAGE-1.
- `done`  out  1  one-cycle frame-complete pulse.

## Operation
- Every output is registered.
- Reset values: `ready`=1; `start`, `dvalid`, `last`, `done`, `data`, `idx` all 0. The snapshot array clears to 0.
- The FSM has four states: IDLE, START, SHIFT and GAP.
  - IDLE: `ready`=1. `load`=1 copies all of `data_d` into the snapshot and moves to START. `abort` in IDLE has no effect.
  - START: `start`=1 for exactly one cycle and `ready`=0. Moves to SHIFT with the word counter at 0.
  - SHIFT: `dvalid`=1, `data`=snapshot[cnt] and `idx`=cnt. `last`=1 when cnt=STAGE-1. The counter increments each cycle; after STAGE-1 the FSM goes to GAP. The counter never wraps inside a frame.
  - GAP: the first cycle carries `done`=1. The FSM stays for max(GAP,1) cycles in total, then returns to IDLE.
- When not in SHIFT, `data` and `idx` are driven to 0.
- `load` while `ready`=0 is ignored, with no queuing and no snapshot update.
- Changes on `data_d` after acceptance do not affect the frame in flight.
- `abort`=1 in START, SHIFT or GAP forces IDLE on the next edge:
  - all strobes go to 0 and `ready` goes to 1 next cycle;
  - no `done` is issued for the aborted frame;
  - the snapshot is retained but not re-sent.
- If `abort` and `load` are both high in IDLE, `load` wins.
- If `abort` and `load` are both high while busy, `abort` wins and `load` is ignored.
- `rst`=0 in any state returns everything to reset values on the next edge, including mid-frame.

## Timing
- Cycle n means the state after rising edge n. Accepted `load` is sampled at edge 0.
- Cycle 1: `start`=1.
- Cycles 2..STAGE+1: `dvalid`=1 carrying word 0..STAGE-1. `last` is high in cycle STAGE+1.
- Cycle STAGE+2: `done`=1.
- `ready`=1 from cycle STAGE+2+max(GAP,1).
- Load-to-first-word latency is 2 cycles.
- Minimum frame period is STAGE+2+max(GAP,1) cycles; with the defaults that is 11.
- `start`, `done` and `dvalid` are mutually exclusive in every cycle.
- `ready` falls in cycle 1 after an accepted load.

## Test plan
- **Reset values.** Hold `rst`=0 for 3 cycles with `load`=1 and random `data_d`, then release. Required: `ready`=1, all other outputs 0, and no `start` while `rst`=0. `load` is accepted on the first edge after release.
- **Basic frame.** `data_d`={0x10,0x21,...,0x87} (defaults), `load` pulse in cycle 0. Required:
  - `start` in cycle 1;
  - `data`=0x10..0x87 with `idx` 0..7 in cycles 2..9;
  - `last` only in cycle 9;
  - `done` in cycle 10;
  - `ready` from cycle 11.
- **Busy load.** Hold `load`=1 continuously while changing `data_d` to 0xFF in cycle 3. Required:
  - the first frame still sends the original words;
  - a second `start` appears in cycle 12 carrying 0xFF words.
- **Abort mid-stream.** Assert `abort` in cycle 5 (word 3 visible). Required:
  - cycle 6 has `dvalid`=0 and `ready`=1;
  - no `done` appears;
  - a new `load` in cycle 6 gives `start` in cycle 7.
- **Abort with load.** Assert both together in IDLE. Required: frame accepted and `start` next cycle. Assert both in SHIFT. Required: IDLE next cycle and no new frame.
- **Parameter sweep.** Run STAGE=2, GAP=0 and STAGE=16, DWIDTH=12, GAP=4. Required:
  - the period matches STAGE+2+max(GAP,1);
  - `idx` stops at STAGE-1;
  - words arrive in order.
